// File: rtl/scope_uart_cmd_parser_pkg.sv
// Shared constants and types for the scope UART command parser.
// Command bytes, ack codes, FSM states and trigger field width.
package scope_cmd_pkg;
  localparam int TRIG_W = 40;

  localparam logic [7:0] CMD_ARM       = 8'h41;
  localparam logic [7:0] CMD_DISARM    = 8'h44;
  localparam logic [7:0] CMD_TRIG_RISE = 8'h52;
  localparam logic [7:0] CMD_TRIG_FALL = 8'h46;
  localparam logic [7:0] ACK_ERR       = 8'h3F;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    COMMIT,
    ACK
  } state_e;
endpackage

// File: rtl/scope_uart_cmd_parser_if.sv
// UART-side byte streams: rx bytes into the parser, ack bytes out.
// master = UART rx/tx side, slave = command parser.
interface scope_uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/scope_uart_cmd_parser.sv
// Byte command decoder: arm/disarm pulses, trigger config, ack byte.
// Trigger payload is 10 bytes: level[39:0] then holdoff[39:0], LSB first.
module scope_uart_cmd_parser
  import scope_cmd_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int PAYLOAD_BYTES  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  scope_uart_cmd_parser_if.slave bus,
  output logic              arm,
  output logic              disarm,
  output logic              trig_we,
  output logic              trig_edge,
  output logic [TRIG_W-1:0] trig_level,
  output logic [TRIG_W-1:0] trig_holdoff,
  output logic              err
);

  if (PAYLOAD_BYTES != 10 || CLK_HZ <= 0 || TIMEOUT_CYCLES < 2)
  begin : g_bad_cfg
    $error("scope_uart_cmd_parser: unsupported configuration");
  end

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [2*TRIG_W-1:0] shadow_q, shadow_d;
  logic              edge_sh_q, edge_sh_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              rx_ready_q, rx_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              arm_q, arm_d;
  logic              disarm_q, disarm_d;
  logic              trig_we_q, trig_we_d;
  logic              err_q, err_d;
  logic              trig_edge_q, trig_edge_d;
  logic [TRIG_W-1:0] trig_level_q, trig_level_d;
  logic [TRIG_W-1:0] trig_holdoff_q, trig_holdoff_d;

  logic rx_fire, tx_fire;
  logic is_arm, is_dis, is_trig;

  assign rx_fire = bus.rx_valid & rx_ready_q;
  assign tx_fire = tx_valid_q & bus.tx_ready;
  assign is_arm  = bus.rx_data == CMD_ARM;
  assign is_dis  = bus.rx_data == CMD_DISARM;
  assign is_trig = (bus.rx_data == CMD_TRIG_RISE) ||
                   (bus.rx_data == CMD_TRIG_FALL);

  // Next-state, pulse and config decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    to_d           = to_q;
    shadow_d       = shadow_q;
    edge_sh_d      = edge_sh_q;
    cmd_d          = cmd_q;
    tx_valid_d     = tx_valid_q;
    tx_data_d      = tx_data_q;
    arm_d          = 1'b0;
    disarm_d       = 1'b0;
    trig_we_d      = 1'b0;
    err_d          = 1'b0;
    trig_edge_d    = trig_edge_q;
    trig_level_d   = trig_level_q;
    trig_holdoff_d = trig_holdoff_q;

    unique case (state_q)
      IDLE: begin
        if (rx_fire) begin
          cmd_d = bus.rx_data;
          unique case (1'b1)
            is_arm, is_dis: begin
              arm_d      = is_arm;
              disarm_d   = is_dis;
              tx_data_d  = bus.rx_data;
              tx_valid_d = 1'b1;
              state_d    = ACK;
            end
            is_trig: begin
              edge_sh_d = bus.rx_data == CMD_TRIG_RISE;
              cnt_d     = '0;
              to_d      = '0;
              state_d   = PAYLOAD;
            end
            default: begin
              err_d      = 1'b1;
              tx_data_d  = ACK_ERR;
              tx_valid_d = 1'b1;
              state_d    = ACK;
            end
          endcase
        end
      end
      PAYLOAD: begin
        if (rx_fire) begin
          shadow_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
          cnt_d = cnt_q + 4'd1;
          to_d  = '0;
          if (cnt_q == LAST_IDX) begin
            trig_edge_d    = edge_sh_q;
            trig_level_d   = shadow_d[TRIG_W-1:0];
            trig_holdoff_d = shadow_d[2*TRIG_W-1:TRIG_W];
            trig_we_d      = 1'b1;
            state_d        = COMMIT;
          end
        end else if (to_q == TO_LAST) begin
          err_d      = 1'b1;
          tx_data_d  = ACK_ERR;
          tx_valid_d = 1'b1;
          state_d    = ACK;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      COMMIT: begin
        tx_data_d  = cmd_q;
        tx_valid_d = 1'b1;
        state_d    = ACK;
      end
      ACK: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rx_ready_d = (state_d == IDLE) || (state_d == PAYLOAD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      to_q           <= '0;
      shadow_q       <= '0;
      edge_sh_q      <= 1'b1;
      cmd_q          <= '0;
      rx_ready_q     <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= '0;
      arm_q          <= 1'b0;
      disarm_q       <= 1'b0;
      trig_we_q      <= 1'b0;
      err_q          <= 1'b0;
      trig_edge_q    <= 1'b1;
      trig_level_q   <= '0;
      trig_holdoff_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      to_q           <= to_d;
      shadow_q       <= shadow_d;
      edge_sh_q      <= edge_sh_d;
      cmd_q          <= cmd_d;
      rx_ready_q     <= rx_ready_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
      arm_q          <= arm_d;
      disarm_q       <= disarm_d;
      trig_we_q      <= trig_we_d;
      err_q          <= err_d;
      trig_edge_q    <= trig_edge_d;
      trig_level_q   <= trig_level_d;
      trig_holdoff_q <= trig_holdoff_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign arm          = arm_q;
  assign disarm       = disarm_q;
  assign trig_we      = trig_we_q;
  assign err          = err_q;
  assign trig_edge    = trig_edge_q;
  assign trig_level   = trig_level_q;
  assign trig_holdoff = trig_holdoff_q;

endmodule

// File: tb/tb_scope_uart_cmd_parser.sv
// Directed bench for scope_uart_cmd_parser.
// Outputs are sampled on the falling edge; inputs change there too.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s: got %0h want %0h", tag, (obs), (exp)); \
    end \
  end

module tb_scope_uart_cmd_parser;
  import scope_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scope_uart_cmd_parser_if bus ();

  logic        arm, disarm, trig_we, trig_edge, err;
  logic [39:0] trig_level, trig_holdoff;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int long_pulse = 0;
  int we_before;
  int bad;
  logic [3:0] prev_p = 4'b0;

  scope_uart_cmd_parser #(
    .CLK_HZ(100000000),
    .TIMEOUT_CYCLES(100),
    .PAYLOAD_BYTES(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .arm(arm),
    .disarm(disarm),
    .trig_we(trig_we),
    .trig_edge(trig_edge),
    .trig_level(trig_level),
    .trig_holdoff(trig_holdoff),
    .err(err)
  );

  // Pulse-width and trig_we monitors.
  always @(negedge clk) begin
    prev_p <= {arm, disarm, trig_we, err};
    if (rst_n && |(prev_p & {arm, disarm, trig_we, err}))
      long_pulse <= long_pulse + 1;
    if (trig_we === 1'b1)
      we_cnt <= we_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Present a byte at the current negedge, return at the negedge after accept.
  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.rx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    `CHK("rx_accept", ok, 1'b1)
  endtask

  task automatic send_payload(input logic [79:0] v);
    for (int i = 0; i < 10; i++) send(v[i*8 +: 8]);
  endtask

  // Ack is visible now; tx_ready=1 completes it at the next edge.
  task automatic ack(input logic [7:0] exp);
    `CHK("ack_valid", bus.tx_valid, 1'b1)
    `CHK("ack_data", bus.tx_data, exp)
    `CHK("ack_rx_ready", bus.rx_ready, 1'b0)
    @(negedge clk);
    `CHK("ack_done", bus.tx_valid, 1'b0)
    `CHK("idle_ready", bus.rx_ready, 1'b1)
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;

    repeat (3) @(negedge clk);
    `CHK("rst_rx_ready", bus.rx_ready, 1'b0)
    `CHK("rst_tx", {bus.tx_valid, bus.tx_data}, 9'h000)
    `CHK("rst_pulses", {arm, disarm, trig_we, err}, 4'b0000)
    `CHK("rst_edge", trig_edge, 1'b1)
    `CHK("rst_level", trig_level, 40'h0)
    `CHK("rst_holdoff", trig_holdoff, 40'h0)
    rst_n = 1'b1;
    @(negedge clk);

    send(CMD_ARM);
    `CHK("arm_pulse", arm, 1'b1)
    ack(8'h41);
    `CHK("arm_single", arm, 1'b0)

    send(CMD_TRIG_RISE);
    send_payload(80'h0040_0000_0000_0000_0000);
    `CHK("r_we", trig_we, 1'b1)
    `CHK("r_edge", trig_edge, 1'b1)
    `CHK("r_level", trig_level, 40'h00_0000_0000)
    `CHK("r_holdoff", trig_holdoff, 40'h00_4000_0000)
    `CHK("r_no_tx_yet", bus.tx_valid, 1'b0)
    @(negedge clk);
    `CHK("r_we_single", trig_we, 1'b0)
    ack(8'h52);

    send(CMD_TRIG_FALL);
    send_payload(80'h5040_3020_1005_0403_0201);
    `CHK("f_we", trig_we, 1'b1)
    `CHK("f_edge", trig_edge, 1'b0)
    `CHK("f_level", trig_level, 40'h05_0403_0201)
    `CHK("f_holdoff", trig_holdoff, 40'h50_4030_2010)
    @(negedge clk);
    ack(8'h46);

    send(8'h7A);
    `CHK("unk_err", err, 1'b1)
    `CHK("unk_cfg", {trig_edge, trig_level, trig_holdoff},
         {1'b0, 40'h05_0403_0201, 40'h50_4030_2010})
    ack(ACK_ERR);
    `CHK("unk_err_single", err, 1'b0)
    send(CMD_ARM);
    `CHK("arm_after_err", arm, 1'b1)
    ack(8'h41);

    we_before = we_cnt;
    send(CMD_TRIG_RISE);
    send(8'h41);
    send(8'h44);
    send(8'h52);
    repeat (99) @(negedge clk);
    `CHK("to_early", {err, bus.tx_valid}, 2'b00)
    @(negedge clk);
    `CHK("to_err", err, 1'b1)
    ack(ACK_ERR);
    `CHK("to_no_we", we_cnt, we_before)
    `CHK("to_cfg", {trig_edge, trig_level, trig_holdoff},
         {1'b0, 40'h05_0403_0201, 40'h50_4030_2010})

    bus.tx_ready = 1'b0;
    send(CMD_DISARM);
    `CHK("disarm_pulse", disarm, 1'b1)
    bus.rx_data  = CMD_ARM;
    bus.rx_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(bus.tx_valid === 1'b1 && bus.tx_data === 8'h44 &&
            bus.rx_ready === 1'b0 && arm === 1'b0))
        bad++;
    end
    `CHK("hold_stable", bad, 0)
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    `CHK("hold_release", bus.tx_valid, 1'b0)

    we_before = we_cnt;
    send(CMD_TRIG_FALL);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    rst_n = 1'b0;
    @(negedge clk);
    `CHK("mrst_rx_ready", bus.rx_ready, 1'b0)
    `CHK("mrst_tx", {bus.tx_valid, bus.tx_data}, 9'h000)
    `CHK("mrst_pulses", {arm, disarm, trig_we, err}, 4'b0000)
    `CHK("mrst_cfg", {trig_edge, trig_level, trig_holdoff},
         {1'b1, 40'h0, 40'h0})
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    `CHK("mrst_no_ack", bus.tx_valid, 1'b0)
    `CHK("mrst_no_we", we_cnt, we_before)
    send(CMD_ARM);
    `CHK("mrst_arm", arm, 1'b1)
    ack(8'h41);

    `CHK("pulse_width", long_pulse, 0)

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
